direction_input_arbiter: RTL and testbench

//  Parametrised N-source controller arbiter for the VGA game datapath. Selects one of NUM_SRC

---
 rtl/direction_input_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_direction_input_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/direction_input_arbiter.sv
// direction_input_arbiter
// Picks one of NUM_SRC decoded game controllers by Choice and turns its raw
// button vector into a clean held level plus press / auto-repeat pulses.
// A source change blanks the outputs for SWITCH_BLANK cycles. A source that
// stops reporting keeps its last value until STALE_CYCLES pass, then drops to
// zero. Opposite directions pressed together cancel each other.
// All outputs are registered.

module direction_input_arbiter #(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned BTN_W        = 4,
  parameter int unsigned SWITCH_BLANK = 16,
  parameter int unsigned STALE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY = 12500000,
  parameter int unsigned REPEAT_RATE  = 2500000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [SEL_W-1:0]         Choice,
  input  logic [NUM_SRC*BTN_W-1:0] Src_Buttons,
  input  logic [NUM_SRC-1:0]       Src_Readable,
  output logic [BTN_W-1:0]         Buttons,
  output logic [BTN_W-1:0]         Pressed,
  output logic [SEL_W-1:0]         Active_Src,
  output logic                     Stale
);

  // Counter widths sized so each counter can hold its terminal value.
  localparam int unsigned BLANK_W  = $clog2(SWITCH_BLANK + 1);
  localparam int unsigned STALE_W  = $clog2(STALE_CYCLES + 1);
  localparam int unsigned RPT_W    = $clog2(REPEAT_DELAY + 1);
  // Every Choice code gets a slot; unused slots read as idle, never selected.
  localparam int unsigned NUM_SLOT = 1 << SEL_W;

  localparam logic [BLANK_W-1:0] BLANK_RELOAD = BLANK_W'(SWITCH_BLANK);
  localparam logic [BLANK_W-1:0] BLANK_ONE    = BLANK_W'(1);
  localparam logic [STALE_W-1:0] STALE_LIMIT  = STALE_W'(STALE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_ONE    = STALE_W'(1);
  localparam logic [RPT_W:0]     RPT_HIT      = (RPT_W + 1)'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0]   RPT_RELOAD   = RPT_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [RPT_W-1:0]   RPT_MAX      = {RPT_W{1'b1}};
  localparam logic [RPT_W:0]     RPT_ONE      = (RPT_W + 1)'(1);
  localparam logic               RPT_EN       = (REPEAT_RATE != 0);
  localparam logic [SEL_W:0]     SRC_COUNT    = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0]   SRC_LAST     = SEL_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALE = 2'd2
  } state_t;

  // Opposite directions cancel: Up+Down and Left+Right both read as released.
  // Bits above Right pass through unchanged.
  function automatic logic [BTN_W-1:0] dir_filter(input logic [BTN_W-1:0] v);
    logic [BTN_W-1:0] r;
    r    = v;
    r[0] = v[0] & ~v[1];
    r[1] = v[1] & ~v[0];
    r[2] = v[2] & ~v[3];
    r[3] = v[3] & ~v[2];
    return r;
  endfunction

  state_t             state_q,     state_d;
  logic [SEL_W-1:0]   sel_q,       sel_d;
  logic [BLANK_W-1:0] blank_q,     blank_d;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
  logic [BTN_W-1:0]   buttons_q,   buttons_d;
  logic [BTN_W-1:0]   pressed_q,   pressed_d;
  logic               stale_q,     stale_d;
  logic [RPT_W-1:0]   rpt_q [BTN_W];
  logic [RPT_W-1:0]   rpt_d [BTN_W];

  logic [BTN_W-1:0]    slot_btn_s [NUM_SLOT];
  logic [NUM_SLOT-1:0] slot_rd_s;
  logic [SEL_W-1:0]    sel_req_s;
  logic [BTN_W-1:0]    src_btn_s;
  logic                src_rd_s;
  logic                switch_s;

  // Spread the flat source bus into one slot per Choice code.
  for (genvar k = 0; k < NUM_SLOT; k++) begin : g_slot
    if (k < NUM_SRC) begin : g_src
      assign slot_btn_s[k] = Src_Buttons[k*BTN_W +: BTN_W];
      assign slot_rd_s[k]  = Src_Readable[k];
    end else begin : g_pad
      assign slot_btn_s[k] = {BTN_W{1'b0}};
      assign slot_rd_s[k]  = 1'b0;
    end
  end

  // Out-of-range Choice codes fall back to the highest real source; the
  // extra top bit keeps the compare correct when NUM_SRC == 2**SEL_W.
  assign sel_req_s = ({1'b0, Choice} >= SRC_COUNT) ? SRC_LAST : Choice;
  assign src_btn_s = dir_filter(slot_btn_s[sel_q]);
  assign src_rd_s  = slot_rd_s[sel_q];
  assign switch_s  = (sel_req_s != sel_q);

  // Source-selection FSM: blanking after a switch, tracking, stale timeout.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    blank_d     = blank_q;
    stale_cnt_d = stale_cnt_q;
    buttons_d   = buttons_q;
    stale_d     = stale_q;
    case (state_q)
      ST_BLANK: begin
        buttons_d = {BTN_W{1'b0}};
        stale_d   = 1'b0;
        if (switch_s) begin
          sel_d   = sel_req_s;
          blank_d = BLANK_RELOAD;
        end else if (blank_q <= BLANK_ONE) begin
          blank_d     = {BLANK_W{1'b0}};
          state_d     = ST_RUN;
          stale_cnt_d = {STALE_W{1'b0}};
        end else begin
          blank_d = blank_q - BLANK_ONE;
        end
      end
      ST_RUN: begin
        if (switch_s) begin
          state_d   = ST_BLANK;
          sel_d     = sel_req_s;
          blank_d   = BLANK_RELOAD;
          buttons_d = {BTN_W{1'b0}};
          stale_d   = 1'b0;
        end else if (src_rd_s) begin
          buttons_d   = src_btn_s;
          stale_cnt_d = {STALE_W{1'b0}};
        end else if ((stale_cnt_q + STALE_ONE) >= STALE_LIMIT) begin
          state_d     = ST_STALE;
          stale_cnt_d = STALE_LIMIT;
          buttons_d   = {BTN_W{1'b0}};
          stale_d     = 1'b1;
        end else begin
          stale_cnt_d = stale_cnt_q + STALE_ONE;
        end
      end
      ST_STALE: begin
        buttons_d = {BTN_W{1'b0}};
        stale_d   = 1'b1;
        if (switch_s) begin
          state_d = ST_BLANK;
          sel_d   = sel_req_s;
          blank_d = BLANK_RELOAD;
          stale_d = 1'b0;
        end else if (src_rd_s) begin
          state_d     = ST_RUN;
          buttons_d   = src_btn_s;
          stale_cnt_d = {STALE_W{1'b0}};
          stale_d     = 1'b0;
        end else begin
          stale_cnt_d = stale_cnt_q;
        end
      end
      default: begin
        state_d   = ST_BLANK;
        blank_d   = BLANK_RELOAD;
        buttons_d = {BTN_W{1'b0}};
        stale_d   = 1'b0;
      end
    endcase
  end

  // Per-button press and auto-repeat pulses, derived from the next held level
  // so a pulse lines up with the cycle its button first shows as pressed.
  always_comb begin
    rpt_d     = rpt_q;
    pressed_d = {BTN_W{1'b0}};
    for (int i = 0; i < BTN_W; i++) begin
      if (!buttons_d[i]) begin
        rpt_d[i] = {RPT_W{1'b0}};
      end else if (!buttons_q[i]) begin
        pressed_d[i] = 1'b1;
        rpt_d[i]     = {RPT_W{1'b0}};
      end else if (RPT_EN && (({1'b0, rpt_q[i]} + RPT_ONE) == RPT_HIT)) begin
        pressed_d[i] = 1'b1;
        rpt_d[i]     = RPT_RELOAD;
      end else if (rpt_q[i] != RPT_MAX) begin
        rpt_d[i] = rpt_q[i] + RPT_ONE[RPT_W-1:0];
      end else begin
        rpt_d[i] = rpt_q[i];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_BLANK;
      sel_q       <= {SEL_W{1'b0}};
      blank_q     <= BLANK_RELOAD;
      stale_cnt_q <= {STALE_W{1'b0}};
      buttons_q   <= {BTN_W{1'b0}};
      pressed_q   <= {BTN_W{1'b0}};
      stale_q     <= 1'b0;
      for (int i = 0; i < BTN_W; i++) begin
        rpt_q[i] <= {RPT_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      blank_q     <= blank_d;
      stale_cnt_q <= stale_cnt_d;
      buttons_q   <= buttons_d;
      pressed_q   <= pressed_d;
      stale_q     <= stale_d;
      for (int i = 0; i < BTN_W; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
    end
  end

  assign Buttons    = buttons_q;
  assign Pressed    = pressed_q;
  assign Active_Src = sel_q;
  assign Stale      = stale_q;

endmodule

// File: tb/tb_direction_input_arbiter.sv
// Testbench for direction_input_arbiter: directed per-cycle vectors with
// hand-computed expectations, pushed into a queue and checked by a monitor
// one step after each rising clock edge.

module tb_direction_input_arbiter;

  logic        clk;
  logic        Reset;
  logic [1:0]  Choice;
  logic [11:0] Src_Buttons;
  logic [2:0]  Src_Readable;
  logic [3:0]  Buttons;
  logic [3:0]  Pressed;
  logic [1:0]  Active_Src;
  logic        Stale;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] p;
    logic [1:0] s;
    logic       st;
  } exp_t;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cycle = 0;

  direction_input_arbiter #(
    .NUM_SRC     (3),
    .SEL_W       (2),
    .BTN_W       (4),
    .SWITCH_BLANK(16),
    .STALE_CYCLES(8),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (4)
  ) dut (
    .Clock       (clk),
    .Reset       (Reset),
    .Choice      (Choice),
    .Src_Buttons (Src_Buttons),
    .Src_Readable(Src_Readable),
    .Buttons     (Buttons),
    .Pressed     (Pressed),
    .Active_Src  (Active_Src),
    .Stale       (Stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input vector for n rising edges, queuing the outputs each
  // edge must produce.
  task automatic step(input logic rst, input logic [1:0] ch, input logic [11:0] btn,
                      input logic [2:0] rd, input logic [3:0] eb, input logic [3:0] ep,
                      input logic [1:0] es, input logic est, input int n);
    exp_t e;
    e.b  = eb;
    e.p  = ep;
    e.s  = es;
    e.st = est;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Reset        = rst;
      Choice       = ch;
      Src_Buttons  = btn;
      Src_Readable = rd;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: after every rising edge, compare outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cycle++;
        n_tests++;
        if ({Buttons, Pressed, Active_Src, Stale} !== e) begin
          n_fail++;
          $display("FAIL outputs edge%0d: got Buttons=%b Pressed=%b Active_Src=%0d Stale=%b, want Buttons=%b Pressed=%b Active_Src=%0d Stale=%b",
                   n_cycle, Buttons, Pressed, Active_Src, Stale, e.b, e.p, e.s, e.st);
        end
      end
    end
  end

  initial begin
    Reset        = 1'b1;
    Choice       = 2'd0;
    Src_Buttons  = 12'h000;
    Src_Readable = 3'b000;

    // Reset, then 16 blank edges with src0 pressing Up; RUN latches on the 17th.
    step(1'b1, 2'd0, 12'h000, 3'b000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1);
    step(1'b0, 2'd0, 12'h401, 3'b111, 4'b0000, 4'b0000, 2'd0, 1'b0, 16);
    step(1'b0, 2'd0, 12'h401, 3'b111, 4'b0001, 4'b0001, 2'd0, 1'b0, 1);
    // Up+Down cancels; Up+Right passes and both pulse.
    step(1'b0, 2'd0, 12'h403, 3'b111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1);
    step(1'b0, 2'd0, 12'h409, 3'b111, 4'b1001, 4'b1001, 2'd0, 1'b0, 1);
    step(1'b0, 2'd0, 12'h400, 3'b111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1);

    // Auto-repeat: pulses at cycles 0,10,14,18,22,26 of a 30-cycle hold.
    step(1'b0, 2'd0, 12'h401, 3'b111, 4'b0001, 4'b0001, 2'd0, 1'b0, 1);
    step(1'b0, 2'd0, 12'h401, 3'b111, 4'b0001, 4'b0000, 2'd0, 1'b0, 9);
    for (int r = 0; r < 5; r++) begin
      step(1'b0, 2'd0, 12'h401, 3'b111, 4'b0001, 4'b0001, 2'd0, 1'b0, 1);
      step(1'b0, 2'd0, 12'h401, 3'b111, 4'b0001, 4'b0000, 2'd0, 1'b0, 3);
    end

    // Stale: hold Left for 7 unreadable cycles, drop on the 8th, recover with Right.
    step(1'b0, 2'd0, 12'h404, 3'b111, 4'b0100, 4'b0100, 2'd0, 1'b0, 1);
    step(1'b0, 2'd0, 12'h400, 3'b110, 4'b0100, 4'b0000, 2'd0, 1'b0, 7);
    step(1'b0, 2'd0, 12'h400, 3'b110, 4'b0000, 4'b0000, 2'd0, 1'b1, 1);
    step(1'b0, 2'd0, 12'h408, 3'b110, 4'b0000, 4'b0000, 2'd0, 1'b1, 2);
    step(1'b0, 2'd0, 12'h408, 3'b111, 4'b1000, 4'b1000, 2'd0, 1'b0, 1);

    // Switch 0->2 while Up held; Choice=3 clamps to 2 and must not restart blanking.
    step(1'b0, 2'd0, 12'h241, 3'b111, 4'b0001, 4'b0001, 2'd0, 1'b0, 1);
    step(1'b0, 2'd2, 12'h241, 3'b111, 4'b0000, 4'b0000, 2'd2, 1'b0, 1);
    step(1'b0, 2'd2, 12'h241, 3'b111, 4'b0000, 4'b0000, 2'd2, 1'b0, 8);
    step(1'b0, 2'd3, 12'h241, 3'b111, 4'b0000, 4'b0000, 2'd2, 1'b0, 8);
    step(1'b0, 2'd3, 12'h241, 3'b111, 4'b0010, 4'b0010, 2'd2, 1'b0, 1);
    // Left+Right cancels while Down is kept held (no new pulse).
    step(1'b0, 2'd3, 12'hE41, 3'b111, 4'b0010, 4'b0000, 2'd2, 1'b0, 1);
    step(1'b0, 2'd3, 12'h241, 3'b111, 4'b0010, 4'b0000, 2'd2, 1'b0, 3);

    // Reset mid-hold: everything clears, then a full blank period from source 0.
    step(1'b1, 2'd3, 12'h241, 3'b111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1);
    step(1'b0, 2'd0, 12'h248, 3'b111, 4'b0000, 4'b0000, 2'd0, 1'b0, 16);
    step(1'b0, 2'd0, 12'h248, 3'b111, 4'b1000, 4'b1000, 2'd0, 1'b0, 1);

    for (int w = 0; w < 8 && exp_q.size() != 0; w++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
